// File: rtl/aha_code_region_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aha_code_region_arbiter
// Brief    : Two-master AHB-Lite arbiter for the code-region SRAM. M0 (CPU code
//            bus) has fixed priority; losing address phases are held and
//            replayed. Optional M1 starvation guard: AHA_CODE_ARB_FAIRNESS_EN.
// Revision : 1.0
// ============================================================================
module aha_code_region_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  M0_HTRANS,
  input  logic [31:0] M0_HADDR,
  input  logic [2:0]  M0_HSIZE,
  input  logic        M0_HWRITE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADYOUT,
  output logic [1:0]  M0_HRESP,
  output logic [31:0] M0_HRDATA,
  input  logic [1:0]  M1_HTRANS,
  input  logic [31:0] M1_HADDR,
  input  logic [2:0]  M1_HSIZE,
  input  logic        M1_HWRITE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADYOUT,
  output logic [1:0]  M1_HRESP,
  output logic [31:0] M1_HRDATA,
  output logic        S_HSEL,
  output logic [1:0]  S_HTRANS,
  output logic [31:0] S_HADDR,
  output logic [2:0]  S_HSIZE,
  output logic        S_HWRITE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic [1:0]  S_HRESP,
  input  logic [31:0] S_HRDATA
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  owner_e      dp_owner;
  owner_e      dp_owner_nxt;
  logic        pend0, pend1;
  logic [31:0] hold_addr0, hold_addr1;
  logic [2:0]  hold_size0, hold_size1;
  logic        hold_write0, hold_write1;

  logic        live0, live1;
  logic        req0, req1;
  logic        slot;
  logic        force1;
  logic        grant0, grant1;
  logic [31:0] src_addr0, src_addr1;
  logic [2:0]  src_size0, src_size1;
  logic        src_write0, src_write1;

  // A master with a held request is stalled; the data-phase owner sees the slave.
  assign M0_HREADYOUT = (dp_owner == OWN_M0) ? S_HREADYOUT : ~pend0;
  assign M1_HREADYOUT = (dp_owner == OWN_M1) ? S_HREADYOUT : ~pend1;
  assign M0_HRESP     = (dp_owner == OWN_M0) ? S_HRESP : 2'b00;
  assign M1_HRESP     = (dp_owner == OWN_M1) ? S_HRESP : 2'b00;
  assign M0_HRDATA    = S_HRDATA;
  assign M1_HRDATA    = S_HRDATA;

  assign live0 = HRESETn & M0_HTRANS[1] & M0_HREADYOUT;
  assign live1 = HRESETn & M1_HTRANS[1] & M1_HREADYOUT;
  assign req0  = pend0 | live0;
  assign req1  = pend1 | live1;

  assign src_addr0  = pend0 ? hold_addr0  : M0_HADDR;
  assign src_size0  = pend0 ? hold_size0  : M0_HSIZE;
  assign src_write0 = pend0 ? hold_write0 : M0_HWRITE;
  assign src_addr1  = pend1 ? hold_addr1  : M1_HADDR;
  assign src_size1  = pend1 ? hold_size1  : M1_HSIZE;
  assign src_write1 = pend1 ? hold_write1 : M1_HWRITE;

  assign slot   = (dp_owner == OWN_NONE) | S_HREADYOUT;
  assign grant0 = slot & req0 & ~(req1 & force1);
  assign grant1 = slot & req1 & (~req0 | force1);

`ifdef AHA_CODE_ARB_FAIRNESS_EN
  logic [7:0] wait_cnt;

  assign force1 = (wait_cnt == MAX_WAIT_C);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wait_cnt <= 8'd0;
    end else if (grant1) begin
      wait_cnt <= 8'd0;
    end else if (pend1 && (wait_cnt != MAX_WAIT_C)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{M0_HTRANS[0], M1_HTRANS[0]};
`else
  assign force1 = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{M0_HTRANS[0], M1_HTRANS[0], MAX_WAIT_C};
`endif

  // Bursts may be interleaved with the other master, so every beat is NONSEQ.
  always_comb begin
    S_HSEL   = 1'b0;
    S_HTRANS = 2'b00;
    S_HADDR  = 32'd0;
    S_HSIZE  = 3'd0;
    S_HWRITE = 1'b0;
    if (grant0) begin
      S_HSEL   = 1'b1;
      S_HTRANS = 2'b10;
      S_HADDR  = src_addr0;
      S_HSIZE  = src_size0;
      S_HWRITE = src_write0;
    end else if (grant1) begin
      S_HSEL   = 1'b1;
      S_HTRANS = 2'b10;
      S_HADDR  = src_addr1;
      S_HSIZE  = src_size1;
      S_HWRITE = src_write1;
    end
  end

  always_comb begin
    S_HWDATA = 32'd0;
    S_HREADY = 1'b1;
    case (dp_owner)
      OWN_M0: begin
        S_HWDATA = M0_HWDATA;
        S_HREADY = S_HREADYOUT;
      end
      OWN_M1: begin
        S_HWDATA = M1_HWDATA;
        S_HREADY = S_HREADYOUT;
      end
      default: ;
    endcase
  end

  always_comb begin
    dp_owner_nxt = dp_owner;
    if (slot) begin
      if (grant0) begin
        dp_owner_nxt = OWN_M0;
      end else if (grant1) begin
        dp_owner_nxt = OWN_M1;
      end else begin
        dp_owner_nxt = OWN_NONE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_owner <= OWN_NONE;
    end else begin
      dp_owner <= dp_owner_nxt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend0       <= 1'b0;
      hold_addr0  <= 32'd0;
      hold_size0  <= 3'd0;
      hold_write0 <= 1'b0;
    end else if (grant0) begin
      pend0 <= 1'b0;
    end else if (live0) begin
      pend0       <= 1'b1;
      hold_addr0  <= M0_HADDR;
      hold_size0  <= M0_HSIZE;
      hold_write0 <= M0_HWRITE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend1       <= 1'b0;
      hold_addr1  <= 32'd0;
      hold_size1  <= 3'd0;
      hold_write1 <= 1'b0;
    end else if (grant1) begin
      pend1 <= 1'b0;
    end else if (live1) begin
      pend1       <= 1'b1;
      hold_addr1  <= M1_HADDR;
      hold_size1  <= M1_HSIZE;
      hold_write1 <= M1_HWRITE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aha_code_region_arbiter.sv
`default_nettype none
// Testbench for aha_code_region_arbiter: directed scenarios plus randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_aha_code_region_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef AHA_CODE_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        M0_HWRITE, M1_HWRITE;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HREADYOUT, M1_HREADYOUT;
  logic [1:0]  M0_HRESP, M1_HRESP;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        S_HSEL;
  logic [1:0]  S_HTRANS;
  logic [31:0] S_HADDR;
  logic [2:0]  S_HSIZE;
  logic        S_HWRITE;
  logic [31:0] S_HWDATA;
  logic        S_HREADY;
  logic        S_HREADYOUT;
  logic [1:0]  S_HRESP;
  logic [31:0] S_HRDATA;

  aha_code_region_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HSIZE(M0_HSIZE),
    .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA), .M0_HREADYOUT(M0_HREADYOUT),
    .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
    .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HSIZE(M1_HSIZE),
    .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA), .M1_HREADYOUT(M1_HREADYOUT),
    .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
    .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HADDR(S_HADDR), .S_HSIZE(S_HSIZE),
    .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [2:0]  s;
    logic        w;
  } req_t;

  // Reference model: a waiting request per master, the data-phase owner
  // (-1 = none) and the M1 wait counter.
  req_t pend_m[2];
  int   owner;
  int   wcnt;
  int   npass;
  int   ntotal;

  // Per-cycle decisions derived by the model from the current inputs.
  bit   m_live[2];
  req_t m_live_req[2];
  req_t m_src[2];
  bit   m_slot;
  int   m_win;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_eval();
    bit rq[2];
    bit rdy[2];
    for (int x = 0; x < 2; x++) begin
      rdy[x] = (owner == x) ? bit'(S_HREADYOUT) : !pend_m[x].v;
    end
    m_live[0] = HRESETn && M0_HTRANS[1] && rdy[0];
    m_live[1] = HRESETn && M1_HTRANS[1] && rdy[1];
    m_live_req[0] = '{1'b1, M0_HADDR, M0_HSIZE, M0_HWRITE};
    m_live_req[1] = '{1'b1, M1_HADDR, M1_HSIZE, M1_HWRITE};
    for (int x = 0; x < 2; x++) begin
      rq[x] = pend_m[x].v || m_live[x];
      m_src[x] = pend_m[x].v ? pend_m[x] : m_live_req[x];
    end
    m_slot = (owner < 0) || S_HREADYOUT;
    m_win = -1;
    if (m_slot) begin
      if (rq[0] && rq[1]) m_win = (FAIR && wcnt >= MAX_WAIT) ? 1 : 0;
      else if (rq[0]) m_win = 0;
      else if (rq[1]) m_win = 1;
    end
  endtask

  task automatic sample();
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_size;
    logic        e_write;
    #1;
    model_eval();
    e_addr = '0; e_size = '0; e_write = 1'b0; e_wdata = '0;
    if (m_win >= 0) begin
      e_addr  = m_src[m_win].a;
      e_size  = m_src[m_win].s;
      e_write = m_src[m_win].w;
    end
    if (owner == 0) e_wdata = M0_HWDATA;
    if (owner == 1) e_wdata = M1_HWDATA;
    check("S_HSEL", 32'(S_HSEL), 32'(m_win >= 0));
    check("S_HTRANS", 32'(S_HTRANS), (m_win >= 0) ? 32'd2 : 32'd0);
    check("S_HADDR", S_HADDR, e_addr);
    check("S_HSIZE", 32'(S_HSIZE), 32'(e_size));
    check("S_HWRITE", 32'(S_HWRITE), 32'(e_write));
    check("S_HWDATA", S_HWDATA, e_wdata);
    check("S_HREADY", 32'(S_HREADY), (owner < 0) ? 32'd1 : 32'(S_HREADYOUT));
    check("M0_HREADYOUT", 32'(M0_HREADYOUT),
          (owner == 0) ? 32'(S_HREADYOUT) : 32'(!pend_m[0].v));
    check("M1_HREADYOUT", 32'(M1_HREADYOUT),
          (owner == 1) ? 32'(S_HREADYOUT) : 32'(!pend_m[1].v));
    check("M0_HRESP", 32'(M0_HRESP), (owner == 0) ? 32'(S_HRESP) : 32'd0);
    check("M1_HRESP", 32'(M1_HRESP), (owner == 1) ? 32'(S_HRESP) : 32'd0);
    check("M0_HRDATA", M0_HRDATA, S_HRDATA);
    check("M1_HRDATA", M1_HRDATA, S_HRDATA);
  endtask

  task automatic model_update();
    bit old_p1;
    old_p1 = pend_m[1].v;
    if (!HRESETn) begin
      pend_m[0].v = 1'b0;
      pend_m[1].v = 1'b0;
      owner = -1;
      wcnt = 0;
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (m_win == x) pend_m[x].v = 1'b0;
        else if (m_live[x]) pend_m[x] = m_live_req[x];
      end
      if (m_slot) owner = m_win;
      if (m_win == 1) wcnt = 0;
      else if (old_p1 && wcnt < MAX_WAIT) wcnt++;
    end
  endtask

  task automatic advance();
    @(posedge HCLK);
    model_update();
    @(negedge HCLK);
  endtask

  task automatic idle_all();
    M0_HTRANS = 2'b00; M0_HADDR = '0; M0_HSIZE = 3'd2; M0_HWRITE = 1'b0; M0_HWDATA = '0;
    M1_HTRANS = 2'b00; M1_HADDR = '0; M1_HSIZE = 3'd2; M1_HWRITE = 1'b0; M1_HWDATA = '0;
    S_HREADYOUT = 1'b1; S_HRESP = 2'b00; S_HRDATA = '0;
  endtask

  initial begin
    int m1_grants;
    int grant_cycle;
    npass = 0; ntotal = 0; owner = -1; wcnt = 0;
    pend_m[0] = '{1'b0, '0, '0, 1'b0};
    pend_m[1] = '{1'b0, '0, '0, 1'b0};
    idle_all();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);

    // Reset held for 3 cycles while M0 keeps a read active.
    M0_HTRANS = 2'b10; M0_HADDR = 32'h40;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rst_hsel", 32'(S_HSEL), 32'd0);
      check("rst_m0rdy", 32'(M0_HREADYOUT), 32'd1);
      check("rst_shready", 32'(S_HREADY), 32'd1);
      advance();
    end
    HRESETn = 1'b1;
    idle_all();

    // M0-only read of 0x100.
    M0_HTRANS = 2'b10; M0_HADDR = 32'h100;
    sample();
    check("m0_addr", S_HADDR, 32'h100);
    check("m0_sel", 32'(S_HSEL), 32'd1);
    advance();
    M0_HTRANS = 2'b00; S_HRDATA = 32'hDEADBEEF;
    sample();
    check("m0_rdata", M0_HRDATA, 32'hDEADBEEF);
    check("m0_nowait", 32'(M0_HREADYOUT), 32'd1);
    advance();
    idle_all();

    // Simultaneous M0 read and M1 write.
    M0_HTRANS = 2'b10; M0_HADDR = 32'h10;
    M1_HTRANS = 2'b10; M1_HADDR = 32'h20; M1_HWRITE = 1'b1;
    sample();
    check("sim_m0_first", S_HADDR, 32'h10);
    advance();
    M0_HTRANS = 2'b00; M1_HTRANS = 2'b00; M1_HWDATA = 32'hA5A5A5A5;
    sample();
    check("sim_m1_wait", 32'(M1_HREADYOUT), 32'd0);
    check("sim_m1_fwd", S_HADDR, 32'h20);
    check("sim_m1_write", 32'(S_HWRITE), 32'd1);
    advance();
    sample();
    check("sim_wdata", S_HWDATA, 32'hA5A5A5A5);
    check("sim_m1_done", 32'(M1_HREADYOUT), 32'd1);
    advance();
    idle_all();
    sample(); advance();

    // Slave wait states on an M0 read while M1 requests.
    M0_HTRANS = 2'b10; M0_HADDR = 32'h30;
    sample(); advance();
    M0_HTRANS = 2'b00; S_HREADYOUT = 1'b0;
    M1_HTRANS = 2'b10; M1_HADDR = 32'h44;
    sample(); advance();
    M1_HTRANS = 2'b00;
    sample();
    check("ws_m1_held", 32'(M1_HREADYOUT), 32'd0);
    check("ws_no_sel", 32'(S_HSEL), 32'd0);
    advance();
    S_HREADYOUT = 1'b1;
    sample();
    check("ws_replay", S_HADDR, 32'h44);
    check("ws_replay_sel", 32'(S_HSEL), 32'd1);
    advance();
    sample(); advance();
    idle_all();

    // Two-cycle ERROR on an M1 access.
    M1_HTRANS = 2'b10; M1_HADDR = 32'h50;
    sample(); advance();
    M1_HTRANS = 2'b00; S_HREADYOUT = 1'b0; S_HRESP = 2'b01;
    sample();
    check("err1_resp", 32'(M1_HRESP), 32'd1);
    check("err1_rdy", 32'(M1_HREADYOUT), 32'd0);
    check("err1_m0", 32'(M0_HRESP), 32'd0);
    advance();
    S_HREADYOUT = 1'b1;
    sample();
    check("err2_resp", 32'(M1_HRESP), 32'd1);
    check("err2_rdy", 32'(M1_HREADYOUT), 32'd1);
    check("err2_m0", 32'(M0_HRESP), 32'd0);
    advance();
    idle_all();
    sample(); advance();

    // M0 streams every cycle; M1 requests once.
    m1_grants = 0; grant_cycle = -1;
    for (int i = 0; i < 16; i++) begin
      M0_HTRANS = 2'b10; M0_HADDR = 32'h1000 + 32'(i * 4);
      M1_HTRANS = (i == 0) ? 2'b10 : 2'b00; M1_HADDR = 32'h2000;
      sample();
      if (S_HSEL && S_HADDR == 32'h2000) begin
        m1_grants++;
        if (grant_cycle < 0) grant_cycle = i;
      end
      advance();
    end
`ifdef AHA_CODE_ARB_FAIRNESS_EN
    check("fair_grant_cycle", 32'(grant_cycle), 32'(MAX_WAIT + 1));
`else
    check("starve_m1", 32'(m1_grants), 32'd0);
`endif
    idle_all();
    repeat (3) begin sample(); advance(); end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      HRESETn     = ($urandom_range(0, 199) != 0);
      M0_HTRANS   = 2'($urandom_range(0, 3));
      M0_HADDR    = $urandom; M0_HSIZE = 3'($urandom_range(0, 2));
      M0_HWRITE   = 1'($urandom); M0_HWDATA = $urandom;
      M1_HTRANS   = 2'($urandom_range(0, 3));
      M1_HADDR    = $urandom; M1_HSIZE = 3'($urandom_range(0, 2));
      M1_HWRITE   = 1'($urandom); M1_HWDATA = $urandom;
      S_HREADYOUT = ($urandom_range(0, 3) != 0);
      S_HRESP     = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      S_HRDATA    = $urandom;
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
